sort_pkt_writer: RTL

Ingress side of the sorting datapath: accepts one packet at a time from a streaming source with val/sop/eop framing, writes its words into the sort buffer RAM at consecutive addresses from 0, then hands the buffer to `bsorter` with a one-cycle `do_work_o` pulse and the last written address.
- Backpressures the source with `ready_o` until the sorter reports completion.
- Sits between the upstream packet source and the buffer RAM / `bsorter` pair.

---
 rtl/sort_pkt_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sort_pkt_writer.sv
// sort_pkt_writer: writes one val/sop/eop framed packet into the sort buffer from address 0,
// then hands it to the sorter. Optional oversize-error build: `define SORT_WR_OVF_ERR_EN.
module sort_pkt_writer #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              val_i,
   input  logic              sop_i,
   input  logic              eop_i,
   output logic              ready_o,
   output logic              wr_en_o,
   output logic [AWIDTH-1:0] wr_addr_o,
   output logic [DWIDTH-1:0] wr_data_o,
   output logic              do_work_o,
   output logic [AWIDTH-1:0] wrpntr_o,
`ifdef SORT_WR_OVF_ERR_EN
   output logic              err_o,
`endif
   input  logic              done_i
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITE     = 2'd1,
      S_HANDOFF   = 2'd2,
      S_WAIT_SORT = 2'd3
   } state_t;

   localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

   state_t              state_q;
   logic [AWIDTH:0]     cnt_q;
   logic                ready_q;
   logic                wr_en_q;
   logic [AWIDTH-1:0]   wr_addr_q;
   logic [DWIDTH-1:0]   wr_data_q;
   logic                do_work_q;
   logic [AWIDTH-1:0]   wrpntr_q;
`ifdef SORT_WR_OVF_ERR_EN
   logic                ovf_q;
   logic                err_q;
`endif

   // Handshake: a beat transfers on a rising edge where val_i & ready_o; sop_i/eop_i/data_i
   // are only meaningful on that edge. ready_o is a register, so it never depends on val_i.
   logic                beat_acc;
   logic                buf_full;
   logic [AWIDTH-1:0]   eop_ptr_d;

   assign beat_acc  = val_i & ready_q;
   assign buf_full  = cnt_q[AWIDTH];
   // An oversize packet stops at the top of the buffer, so its last written word is all-ones.
   assign eop_ptr_d = buf_full ? {AWIDTH{1'b1}} : cnt_q[AWIDTH-1:0];

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         do_work_q <= 1'b0;
         wrpntr_q  <= '0;
`ifdef SORT_WR_OVF_ERR_EN
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         wr_en_q   <= 1'b0;
         do_work_q <= 1'b0;
`ifdef SORT_WR_OVF_ERR_EN
         err_q     <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               cnt_q   <= '0;
               if (beat_acc && sop_i) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= '0;
                  wr_data_q <= data_i;
                  cnt_q     <= CNT_ONE;
                  if (eop_i) begin
                     wrpntr_q <= '0;
                     ready_q  <= 1'b0;
                     state_q  <= S_HANDOFF;
`ifdef SORT_WR_OVF_ERR_EN
                     ovf_q    <= 1'b0;
`endif
                  end else begin
                     state_q  <= S_WRITE;
                  end
               end
            end

            S_WRITE: begin
               if (beat_acc) begin
                  if (sop_i) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= '0;
                     wr_data_q <= data_i;
                     cnt_q     <= CNT_ONE;
                  end else if (!buf_full) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= cnt_q[AWIDTH-1:0];
                     wr_data_q <= data_i;
                     cnt_q     <= cnt_q + CNT_ONE;
                  end
                  if (eop_i) begin
                     wrpntr_q <= sop_i ? {AWIDTH{1'b0}} : eop_ptr_d;
                     ready_q  <= 1'b0;
                     state_q  <= S_HANDOFF;
`ifdef SORT_WR_OVF_ERR_EN
                     ovf_q    <= ~sop_i & buf_full;
`endif
                  end
               end
            end

            S_HANDOFF: begin
`ifdef SORT_WR_OVF_ERR_EN
               if (ovf_q) begin
                  err_q   <= 1'b1;
                  ovf_q   <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  do_work_q <= 1'b1;
                  state_q   <= S_WAIT_SORT;
               end
`else
               do_work_q <= 1'b1;
               state_q   <= S_WAIT_SORT;
`endif
            end

            S_WAIT_SORT: begin
               // ready_q is raised by IDLE on the following edge.
               if (done_i) begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o   = ready_q;
   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign do_work_o = do_work_q;
   assign wrpntr_o  = wrpntr_q;
`ifdef SORT_WR_OVF_ERR_EN
   assign err_o     = err_q;
`endif

endmodule
